// File: rtl/pixel_aer_arbiter_fifo.sv
// Round-robin group-snapshot arbiter for a ROWS x COLS event-pixel array, feeding AER words through a FWFT FIFO.
// Optional macro OVERFLOW_DROP_EN: grants never stall on a full FIFO; overflowing events are counted in drop_cnt_o.
module pixel_aer_arbiter_fifo #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int POLARITY   = 2,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_ADD    = $clog2(ROWS),
  parameter int COL_ADD    = $clog2(COLS),
  parameter int WIDTH      = ROW_ADD + COL_ADD + TS_WIDTH + 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0]   set_i,
  output logic [ROWS-1:0][COLS-1:0]                 gnt_o,
  output logic                                      grp_release_o,
  output logic                                      evt_valid_o,
  input  logic                                      evt_ready_i,
  output logic [WIDTH-1:0]                          evt_data_o,
  output logic [$clog2(FIFO_DEPTH):0]               fifo_count_o,
  output logic [7:0]                                drop_cnt_o
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, RELEASE} state_t;

  state_t              state;
  logic [N-1:0]        req;
  logic [N-1:0]        pol;
  logic [N-1:0]        pending;
  logic [N-1:0]        live;
  logic [N-1:0]        sel_mask;
  logic [N-1:0]        remain;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    sel_idx;
  logic [ROW_ADD-1:0]  sel_row;
  logic [COL_ADD-1:0]  sel_col;
  logic                sel_found;
  logic                grant;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0]    word;
  logic [WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;

  always_comb begin
    req = '0;
    pol = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        req[r*COLS+c] = |set_i[r][c];
        pol[r*COLS+c] = set_i[r][c][1];
      end
    end
  end

  // Requests withdrawn before their grant simply vanish from the snapshot.
  assign live = pending & req;

  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_row   = '0;
    sel_col   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_found && live[idx[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
        sel_row   = ROW_ADD'(idx / COLS);
        sel_col   = COL_ADD'(idx % COLS);
      end
    end
  end

  assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign sel_mask  = {{(N-1){1'b0}}, 1'b1} << sel_idx;
  assign remain    = live & ~sel_mask;

`ifdef OVERFLOW_DROP_EN
  assign grant = (state == SCAN) && sel_found;
`else
  assign grant = (state == SCAN) && sel_found && !fifo_full;
`endif

  assign push = grant && !fifo_full;
  assign pop  = (count != '0) && evt_ready_i;
  assign word = {sel_row, sel_col, ts, pol[sel_idx]};

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[sel_row][sel_col] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ts <= '0;
    else         ts <= ts + 1'b1;
  end

  // Releasing straight from the final grant keeps the pulse one cycle after it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      pending       <= '0;
      last          <= IDX_W'(N-1);
      grp_release_o <= 1'b0;
    end else begin
      grp_release_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            pending <= req;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!sel_found) begin
            pending       <= '0;
            state         <= RELEASE;
            grp_release_o <= 1'b1;
          end else if (grant) begin
            pending <= remain;
            last    <= sel_idx;
            if (remain == '0) begin
              state         <= RELEASE;
              grp_release_o <= 1'b1;
            end
          end else begin
            pending <= live;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt_valid_o  = (count != '0);
  assign evt_data_o   = evt_valid_o ? mem[rd_ptr] : '0;
  assign fifo_count_o = count;

`ifdef OVERFLOW_DROP_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                         drop_cnt <= '0;
    else if (grant && fifo_full && drop_cnt != 8'hFF)    drop_cnt <= drop_cnt + 1'b1;
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pixel_aer_arbiter_fifo.sv
// Self-checking bench for pixel_aer_arbiter_fifo: directed groups plus random groups against a queue-based model.
module tb_pixel_aer_arbiter_fifo;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int N     = ROWS * COLS;
  localparam int DEPTH = 4;
  localparam int WIDTH = 13;
`ifdef OVERFLOW_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [3:0][3:0][1:0]   set_i;
  logic [3:0][3:0]        gnt_o;
  logic                   grp_release_o;
  logic                   evt_valid_o;
  logic                   evt_ready_i;
  logic [WIDTH-1:0]       evt_data_o;
  logic [2:0]             fifo_count_o;
  logic [7:0]             drop_cnt_o;

  pixel_aer_arbiter_fifo #(
    .ROWS(ROWS), .COLS(COLS), .POLARITY(2), .TS_WIDTH(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .set_i(set_i), .gnt_o(gnt_o),
    .grp_release_o(grp_release_o), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_data_o(evt_data_o), .fifo_count_o(fifo_count_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycles since reset release: the timestamp the DUT should stamp in the current cycle.
  int cyc;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  logic [1:0]       pix [N];
  int               grant_q [$];
  logic [WIDTH-1:0] fifo_q [$];
  int               last_idx = N - 1;
  int               drops = 0;
  bit               active = 1'b0;
  bit               armed = 1'b0;
  bit               rel_exp = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drivePixels();
    for (int i = 0; i < N; i++) set_i[2'(i / COLS)][2'(i % COLS)] = pix[4'(i)];
  endtask

  task automatic raise(input int idx, input logic [1:0] p);
    pix[4'(idx)] = p;
    drivePixels();
    armed = 1'b1;
  endtask

  // One clock cycle: check outputs against the model, advance the model, then act as the pixels and sink.
  task automatic applyStimulus(input bit rdy_next);
    logic [N-1:0] gexp;
    bit full, do_grant, do_pop;
    int gi, j;
    @(negedge clk_i);
    full     = (fifo_q.size() == DEPTH);
    gexp     = '0;
    do_grant = 1'b0;
    gi       = 0;
    if (active && grant_q.size() > 0 && (DROP || !full)) begin
      gi       = grant_q[0];
      gexp     = 16'(1) << gi;
      do_grant = 1'b1;
    end
    checkOutput("gnt", 32'(gnt_o), 32'(gexp));
    checkOutput("grp_release", 32'(grp_release_o), 32'(rel_exp));
    checkOutput("fifo_count", 32'(fifo_count_o), 32'(fifo_q.size()));
    checkOutput("evt_valid", 32'(evt_valid_o), 32'(fifo_q.size() != 0));
    checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(drops));
    if (fifo_q.size() > 0) checkOutput("evt_data", 32'(evt_data_o), 32'(fifo_q[0]));
    do_pop  = (fifo_q.size() > 0) && evt_ready_i;
    rel_exp = 1'b0;
    if (do_pop) void'(fifo_q.pop_front());
    if (do_grant) begin
      void'(grant_q.pop_front());
      last_idx = gi;
      if (!full) fifo_q.push_back({2'(gi / COLS), 2'(gi % COLS), 8'(cyc), pix[4'(gi)][1]});
      else if (drops < 255) drops++;
      if (grant_q.size() == 0) begin
        rel_exp = 1'b1;
        active  = 1'b0;
      end
    end
    if (armed) begin
      for (int k = 1; k <= N; k++) begin
        j = (last_idx + k) % N;
        if (pix[4'(j)] != 2'b00) grant_q.push_back(j);
      end
      active = 1'b1;
      armed  = 1'b0;
    end
    @(posedge clk_i);
    #1;
    if (do_grant) begin
      pix[4'(gi)] = 2'b00;
      drivePixels();
    end
    evt_ready_i = rdy_next;
  endtask

  // mode 0: always ready, 1: random ready, 2: not ready for 8 cycles then ready.
  task automatic runGroup(input int mode);
    int budget;
    bit r;
    budget = 0;
    while ((active || armed || rel_exp || fifo_q.size() > 0) && budget < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = (budget >= 8);
      endcase
      applyStimulus(r);
      budget++;
    end
    if (budget >= 300) checkOutput("group_timeout", 32'(budget), 32'(0));
    applyStimulus(1'b1);
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    #1;
    checkOutput("rst_gnt", 32'(gnt_o), 32'(0));
    checkOutput("rst_count", 32'(fifo_count_o), 32'(0));
    checkOutput("rst_valid", 32'(evt_valid_o), 32'(0));
    checkOutput("rst_data", 32'(evt_data_o), 32'(0));
    checkOutput("rst_release", 32'(grp_release_o), 32'(0));
    checkOutput("rst_drop", 32'(drop_cnt_o), 32'(0));
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    fifo_q.delete();
    grant_q.delete();
    active   = 1'b0;
    rel_exp  = 1'b0;
    last_idx = N - 1;
    drops    = 0;
    armed    = 1'b0;
    for (int i = 0; i < N; i++) if (pix[4'(i)] != 2'b00) armed = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget, cnt, idx;
    reset_i     = 1'b1;
    evt_ready_i = 1'b0;
    for (int i = 0; i < N; i++) pix[4'(i)] = 2'b00;
    drivePixels();
    #12;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);

    evt_ready_i = 1'b1;
    raise(2*COLS + 1, 2'b10);
    runGroup(0);

    raise(0, 2'b01);
    raise(3, 2'b11);
    raise(15, 2'b10);
    runGroup(0);

    raise(5, 2'b10);
    runGroup(0);
    raise(2, 2'b01);
    raise(9, 2'b11);
    runGroup(0);

    evt_ready_i = 1'b0;
    raise(1, 2'b10); raise(4, 2'b01); raise(6, 2'b11);
    raise(8, 2'b10); raise(11, 2'b01); raise(13, 2'b10);
    runGroup(2);

    budget = 0;
    while ((cyc % 256) != 254 && budget < 600) begin
      applyStimulus(1'b1);
      budget++;
    end
    checkOutput("ts_align_timeout", 32'(budget >= 600), 32'(0));
    raise(7, 2'b10);
    raise(10, 2'b01);
    runGroup(0);

    evt_ready_i = 1'b0;
    raise(1, 2'b10); raise(4, 2'b01); raise(6, 2'b11);
    raise(8, 2'b10); raise(11, 2'b01); raise(13, 2'b10);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    doReset();
    runGroup(0);

    for (int g = 0; g < 20; g++) begin
      cnt = $urandom_range(1, 8);
      for (int k = 0; k < cnt; k++) begin
        idx = $urandom_range(0, N - 1);
        raise(idx, 2'($urandom_range(1, 3)));
      end
      runGroup(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
